isect_scheduler: RTL

- Sequences one ray against a stream of triangles through the `intersection` datapath and reduces the results to the closest hit.
- Sits between the triangle fetch logic (upstream valid/ready stream) and the pipelined `intersection` unit.
- Issues at most one triangle per cycle, bounds the number of outstanding triangles, and reports hit, t and triangle index when the job completes.

---
 rtl/isect_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/isect_scheduler.sv
// Ray/triangle job scheduler: streams triangles into the pipelined intersection
// unit with a bounded number in flight and reduces in-order results to the closest hit.
module isect_scheduler #(
  parameter int unsigned MAX_INFLIGHT = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [191:0]     i_ray,
  input  logic [CNT_W-1:0] i_tri_cnt,
  output logic             o_busy,
  input  logic             i_tri_valid,
  output logic             o_tri_ready,
  input  logic [287:0]     i_tri,
  output logic             o_isect_en,
  output logic [287:0]     o_isect_tri,
  output logic [191:0]     o_isect_ray,
  input  logic             i_isect_valid,
  input  logic             i_isect_result,
  input  logic [31:0]      i_isect_t,
  output logic             o_done,
  output logic             o_hit,
  output logic [31:0]      o_t,
  output logic [CNT_W-1:0] o_tri_index
);

  localparam logic [7:0]       MAX_IF  = 8'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [31:0]      T_MAX   = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] tri_cnt_q;
  logic [CNT_W-1:0] issue_idx;
  logic [CNT_W-1:0] ret_idx;
  logic [CNT_W-1:0] best_idx;
  logic [CNT_W-1:0] issue_idx_inc;
  logic [CNT_W-1:0] ret_idx_inc;
  logic [7:0]       inflight;
  logic [31:0]      best_t;
  logic             best_hit;

  logic start_ok;
  logic hs;
  logic ret;
  logic better;

  assign issue_idx_inc = issue_idx + CNT_ONE;
  assign ret_idx_inc   = ret_idx + CNT_ONE;

  assign start_ok = i_start && (state == S_IDLE);
  assign hs       = i_tri_valid && o_tri_ready;
  // A result with nothing outstanding is a leftover from an aborted job.
  assign ret      = i_isect_valid && (inflight != 8'd0);
  assign better   = ret && i_isect_result && ($signed(i_isect_t) < $signed(best_t));

  always_comb begin
    o_busy      = (state != S_IDLE);
    o_tri_ready = (state == S_ISSUE) && (inflight < MAX_IF);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nxt = (i_tri_cnt == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hs && (issue_idx_inc == tri_cnt_q)) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((ret ? ret_idx_inc : ret_idx) == tri_cnt_q) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tri_cnt_q   <= '0;
      issue_idx   <= '0;
      ret_idx     <= '0;
      best_idx    <= '0;
      inflight    <= '0;
      best_t      <= '0;
      best_hit    <= 1'b0;
      o_isect_ray <= '0;
    end else if (start_ok) begin
      tri_cnt_q   <= i_tri_cnt;
      issue_idx   <= '0;
      ret_idx     <= '0;
      best_idx    <= '0;
      inflight    <= '0;
      best_t      <= T_MAX;
      best_hit    <= 1'b0;
      o_isect_ray <= i_ray;
    end else begin
      if (hs) begin
        issue_idx <= issue_idx_inc;
      end
      if (ret) begin
        ret_idx <= ret_idx_inc;
      end
      unique case ({hs, ret})
        2'b10:   inflight <= inflight + 8'd1;
        2'b01:   inflight <= inflight - 8'd1;
        default: inflight <= inflight;
      endcase
      // Strict compare: an equal t from a later triangle keeps the lower index.
      if (better) begin
        best_t   <= i_isect_t;
        best_idx <= ret_idx;
        best_hit <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_isect_en  <= 1'b0;
      o_isect_tri <= '0;
    end else begin
      o_isect_en <= hs;
      if (hs) begin
        o_isect_tri <= i_tri;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_done      <= 1'b0;
      o_hit       <= 1'b0;
      o_t         <= '0;
      o_tri_index <= '0;
    end else begin
      o_done <= (state == S_DONE);
      if (state == S_DONE) begin
        o_hit       <= best_hit;
        o_t         <= best_t;
        o_tri_index <= best_idx;
      end
    end
  end

endmodule
